// File: rtl/dot11_rx_ctrl_pkg.sv
// Shared encodings for the dot11 receive sequencer: FSM states, packet status codes
// and a helper that sizes the sample timer.
package dot11_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_FLUSH   = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    ST_FCS_OK  = 2'd0,
    ST_FCS_ERR = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_PREEMPT = 2'd3
  } rx_status_e;

  localparam int BYTE_CNT_W = 16;

  // Width needed to hold the larger of the two timeout limits.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dot11_rx_ctrl_sample_timer.sv
// Sample-strobe counter for the receive sequencer: cleared on request, saturates,
// and flags when the count has reached the supplied limit.
module dot11_rx_ctrl_sample_timer #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear takes precedence so a strobe landing on a state entry is not counted.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q >= limit);

endmodule

// File: rtl/dot11_rx_ctrl.sv
// Receive sequencer around the dot11 core: arms preamble search, supervises each packet
// through FCS with sample-based timeouts, flushes the core and keeps packet statistics.
//
// state     | meaning
// S_IDLE    | reception disabled, core held in reset
// S_ARM     | core enabled, waiting for short preamble or header
// S_HEADER  | preamble seen, waiting for header (HDR_TIMEOUT samples)
// S_PAYLOAD | counting bytes until FCS (BYTE_TIMEOUT samples per gap)
// S_FLUSH   | core reset for RST_CYCLES clocks, core strobes ignored
module dot11_rx_ctrl
  import dot11_rx_ctrl_pkg::*;
#(
  parameter int HDR_TIMEOUT  = 800,
  parameter int BYTE_TIMEOUT = 200,
  parameter int RST_CYCLES   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_enable,
  input  logic                  tx_busy,
  input  logic                  stat_clr,
  input  logic                  sample_in_strobe,
  input  logic                  short_preamble_detected,
  input  logic                  pkt_header_valid_strobe,
  input  logic [15:0]           pkt_len,
  input  logic                  byte_out_strobe,
  input  logic                  fcs_out_strobe,
  input  logic                  fcs_ok,
  output logic                  core_enable,
  output logic                  core_reset,
  output logic [2:0]            ctrl_state,
  output logic                  pkt_done_stb,
  output logic [1:0]            pkt_status,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0]      pkt_ok_cnt,
  output logic [CNT_W-1:0]      pkt_err_cnt,
  output logic [CNT_W-1:0]      abort_cnt
);

  localparam int TMR_W = timer_width(HDR_TIMEOUT, BYTE_TIMEOUT);
  localparam int FL_W  = $clog2(RST_CYCLES + 1);
  localparam logic [TMR_W-1:0] HDR_LIM  = TMR_W'(HDR_TIMEOUT);
  localparam logic [TMR_W-1:0] BYTE_LIM = TMR_W'(BYTE_TIMEOUT);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(RST_CYCLES - 1);

  rx_state_e             state_q, state_d;
  rx_status_e            status_q, status_d;
  logic [FL_W-1:0]       flush_q, flush_d;
  logic                  spd_q, spd_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic                  done_stb_q, done_stb_d;
  logic                  core_en_q, core_en_d;
  logic                  core_rst_q, core_rst_d;
  logic [CNT_W-1:0]      ok_q, ok_d;
  logic [CNT_W-1:0]      err_q, err_d;
  logic [CNT_W-1:0]      abort_q, abort_d;

  logic             rx_go;
  logic             tmr_clr;
  logic             tmr_expired;
  logic [TMR_W-1:0] tmr_limit;
  logic             unused_pkt_len;

  assign rx_go     = rx_enable && !tx_busy;
  assign tmr_limit = (state_q == S_HEADER) ? HDR_LIM : BYTE_LIM;

  dot11_rx_ctrl_sample_timer #(.W(TMR_W)) u_sample_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (tmr_clr),
    .tick    (sample_in_strobe),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    flush_d    = flush_q;
    byte_cnt_d = byte_cnt_q;
    pkt_len_d  = pkt_len_q;
    done_stb_d = 1'b0;
    tmr_clr    = 1'b0;
    spd_d      = short_preamble_detected;

    unique case (state_q)
      S_IDLE: begin
        if (rx_go) state_d = S_ARM;
      end
      S_ARM: begin
        if (!rx_go) begin
          state_d = S_IDLE;
        end else if (pkt_header_valid_strobe) begin
          state_d    = S_PAYLOAD;
          pkt_len_d  = pkt_len;
          byte_cnt_d = '0;
        end else if (short_preamble_detected && !spd_q) begin
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!rx_go) begin
          state_d    = S_FLUSH;
          status_d   = ST_PREEMPT;
          done_stb_d = 1'b1;
        end else if (pkt_header_valid_strobe) begin
          state_d    = S_PAYLOAD;
          pkt_len_d  = pkt_len;
          byte_cnt_d = '0;
        end else if (tmr_expired) begin
          state_d    = S_FLUSH;
          status_d   = ST_TIMEOUT;
          done_stb_d = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (byte_out_strobe) begin
          tmr_clr = 1'b1;
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
        end
        // A completed FCS is reported even when preemption lands in the same cycle.
        if (fcs_out_strobe) begin
          state_d    = S_FLUSH;
          status_d   = fcs_ok ? ST_FCS_OK : ST_FCS_ERR;
          done_stb_d = 1'b1;
        end else if (!rx_go) begin
          state_d    = S_FLUSH;
          status_d   = ST_PREEMPT;
          done_stb_d = 1'b1;
        end else if (tmr_expired) begin
          state_d    = S_FLUSH;
          status_d   = ST_TIMEOUT;
          done_stb_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_q == '0) begin
          state_d = rx_go ? S_ARM : S_IDLE;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmr_clr = 1'b1;
    if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) flush_d = FL_LOAD;

    core_en_d  = (state_d == S_ARM) || (state_d == S_HEADER) || (state_d == S_PAYLOAD);
    core_rst_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
  end

  always_comb begin
    ok_d    = ok_q;
    err_d   = err_q;
    abort_d = abort_q;
    if (stat_clr) begin
      ok_d    = '0;
      err_d   = '0;
      abort_d = '0;
    end else if (done_stb_d) begin
      unique case (status_d)
        ST_FCS_OK:  if (ok_q != '1) ok_d = ok_q + 1'b1;
        ST_FCS_ERR: if (err_q != '1) err_d = err_q + 1'b1;
        default:    if (abort_q != '1) abort_d = abort_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      status_q   <= ST_FCS_OK;
      flush_q    <= '0;
      spd_q      <= 1'b0;
      byte_cnt_q <= '0;
      pkt_len_q  <= '0;
      done_stb_q <= 1'b0;
      core_en_q  <= 1'b0;
      core_rst_q <= 1'b1;
      ok_q       <= '0;
      err_q      <= '0;
      abort_q    <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      flush_q    <= flush_d;
      spd_q      <= spd_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_len_q  <= pkt_len_d;
      done_stb_q <= done_stb_d;
      core_en_q  <= core_en_d;
      core_rst_q <= core_rst_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  // Header length is held for the host side; nothing in this block consumes it yet.
  assign unused_pkt_len = ^pkt_len_q;

  assign ctrl_state   = state_q;
  assign pkt_status   = status_q;
  assign pkt_done_stb = done_stb_q;
  assign byte_cnt     = byte_cnt_q;
  assign core_enable  = core_en_q;
  assign core_reset   = core_rst_q;
  assign pkt_ok_cnt   = ok_q;
  assign pkt_err_cnt  = err_q;
  assign abort_cnt    = abort_q;

endmodule

// File: doc/dot11_rx_ctrl.md
Name: dot11_rx_ctrl

Overview:
- Receive sequencer wrapped around the dot11 core. It drives the core's enable/reset and arms it for preamble search.
- Supervises each packet from short-preamble detect through FCS, and aborts on header/byte timeouts or TX preemption.
- After every packet or abort, it issues a clean core reset and emits a per-packet status strobe plus saturating statistics counters for the host register file.

Parameters:
HDR_TIMEOUT, 800, samples (sample_in_strobe pulses) allowed from short preamble to pkt_header_valid_strobe
BYTE_TIMEOUT, 200, samples allowed between consecutive byte_out_strobe, or from header to first byte, or from last byte to fcs_out_strobe
RST_CYCLES, 4, clock cycles core_reset is held in S_FLUSH (>=1)
CNT_W, 16, width of statistics counters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
rx_enable  in  1  host enable for reception
tx_busy  in  1  local transmitter active; preempts reception
stat_clr  in  1  pulse; clears all statistics counters
sample_in_strobe  in  1  20 MS/s sample strobe (timeout time base)
short_preamble_detected  in  1  from core
pkt_header_valid_strobe  in  1  from core
pkt_len  in  16  payload length in bytes, valid with header strobe
byte_out_strobe  in  1  from core
fcs_out_strobe  in  1  from core
fcs_ok  in  1  valid with fcs_out_strobe
core_enable  out  1  to dot11 enable
core_reset  out  1  to dot11 reset
ctrl_state  out  3  current FSM state
pkt_done_stb  out  1  one-cycle pulse at packet end/abort
pkt_status  out  2  0 FCS ok, 1 FCS error, 2 timeout, 3 preempted; valid with pkt_done_stb
byte_cnt  out  16  bytes received in current packet
pkt_ok_cnt, pkt_err_cnt, abort_cnt  out  CNT_W each  saturating statistics

Behaviour:
Reset values:
- State S_IDLE; core_enable 0; core_reset 1.
- pkt_done_stb 0; pkt_status 0; byte_cnt 0; all counters 0.

Outputs: all registered. core_reset=1 in S_IDLE and S_FLUSH; core_enable=1 only in S_ARM, S_HEADER, S_PAYLOAD.

States and transitions:
- S_IDLE(0):
  - rx_enable & !tx_busy -> S_ARM.
- S_ARM(1):
  - !rx_enable | tx_busy -> S_IDLE, no status strobe.
  - pkt_header_valid_strobe -> S_PAYLOAD. This takes priority over short_preamble_detected.
  - Rising edge of short_preamble_detected -> S_HEADER, timer cleared.
- S_HEADER(2):
  - pkt_header_valid_strobe -> S_PAYLOAD; latch pkt_len; clear byte_cnt and timer.
  - Timer reaches HDR_TIMEOUT -> S_FLUSH, status 2.
- S_PAYLOAD(3):
  - Each byte_out_strobe increments byte_cnt (saturating at 0xFFFF) and clears the timer.
  - fcs_out_strobe -> S_FLUSH with status = fcs_ok ? 0 : 1.
  - Timer reaches BYTE_TIMEOUT -> S_FLUSH, status 2.
- S_HEADER and S_PAYLOAD: !rx_enable | tx_busy -> S_FLUSH, status 3.
- S_FLUSH(4):
  - Remain exactly RST_CYCLES cycles, then -> S_ARM if rx_enable & !tx_busy, else S_IDLE.
  - All core strobes are ignored.

Timing:
- pkt_done_stb and pkt_status are asserted in the first S_FLUSH cycle, i.e. one cycle after the terminating event.
- core_reset rises in that same cycle.

Timer:
- Counts sample_in_strobe pulses only, not clocks.
- Cleared on every state entry.

Priority within one cycle: fcs_out_strobe > preemption (tx_busy/!rx_enable) > timeout.

Counters:
- Status 0 increments pkt_ok_cnt; status 1 increments pkt_err_cnt; status 2 or 3 increments abort_cnt.
- All counters saturate at 2^CNT_W-1.
- stat_clr wins over a coincident increment.

Reset asserted mid-packet: immediate return to reset values; no status strobe.

Decomposition:
- State encodings (S_IDLE..S_FLUSH) and status codes (ST_FCS_OK, ST_FCS_ERR, ST_TIMEOUT, ST_PREEMPT) go in common_params.v, alongside the existing dot11 state constants.
- One sub-module, sample_timer: a counter clearable per state entry that increments on sample_in_strobe and exposes a >=limit compare. It is instantiated once, with the limit muxed by state.

Test Plan:
- rx_enable=1, preamble at sample 100, header strobe with pkt_len=100, 100 bytes at 1 per 80 samples, fcs_ok=1 -> pkt_status=0, byte_cnt=100, pkt_ok_cnt=1, core_reset high exactly 4 cycles, then state=S_ARM.
- Same packet with fcs_ok=0 -> pkt_status=1, pkt_err_cnt=1, pkt_ok_cnt unchanged.
- short_preamble_detected rises, no header for 800 samples -> pkt_done_stb one sample after limit with status 2, abort_cnt=1; repeat with 799 samples then header -> no abort.
- tx_busy asserted mid-payload after 40 bytes -> status 3, byte_cnt=40, abort_cnt=1, state S_IDLE after flush while tx_busy high; fcs_out_strobe coincident with tx_busy -> status 0 instead.
- Force pkt_ok_cnt to 0xFFFF (65535 packets or preload), one more good packet -> remains 0xFFFF; stat_clr coincident with fcs_out_strobe -> counter reads 0.
- reset pulse during S_PAYLOAD -> next cycle state S_IDLE, core_reset=1, core_enable=0, no pkt_done_stb, counters 0.
